// File: rtl/prio_irq_ctrl.sv
// rtl/prio_irq_ctrl.sv - fixed-priority edge-capturing interrupt controller
//
// Captures rising edges on irq_in into pending, picks the lowest-index
// unmasked pending line and presents it to one consumer through an
// irq_out/ack/eoi handshake. Only one interrupt is outstanding at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   irq_in     raw interrupt lines (rising edge raises a request)
//   mask       1 = line blocked from selection (capture still happens)
//   irq_out    interrupt presented to consumer
//   irq_id     index of presented / in-service interrupt
//   in_service consumer has acked and not yet issued eoi
//   pending    captured, not-yet-acked requests
//   ack        consumer accepts the presented interrupt
//   eoi        consumer finished servicing
//   timeout    one-cycle pulse when an unacked request is abandoned
//
// Optional feature: define IRQ_TIMEOUT_EN to abandon a request after
// ACK_TIMEOUT cycles in REQ without ack. Undefined, timeout is tied 0.

module prio_irq_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int ID_W        = $clog2(N_IRQ),
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
  output logic             irq_out,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending,
  input  logic             ack,
  input  logic             eoi,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  winner;

  assign eligible = pending & ~mask;

  // Scan from the top down so the lowest set index is the last to win.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // The accepted line leaves pending on the ack cycle.
  always_comb begin
    clr = '0;
    if (state == REQ && ack) clr[irq_id] = 1'b1;
  end

  // A fresh edge on the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~clr) | (irq_in & ~irq_prev);
    end
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (ACK_TIMEOUT > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      cnt        <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
`ifdef IRQ_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|eligible) begin
            irq_id  <= winner;
            irq_out <= 1'b1;
            state   <= REQ;
`ifdef IRQ_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        REQ: begin
          // No preemption and no retraction on mask: irq_id holds until ack.
          if (ack) begin
            irq_out    <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end
`ifdef IRQ_TIMEOUT_EN
          // This cycle is the ACK_TIMEOUT-th unacked REQ cycle; pending
          // is left set so the line is offered again.
          else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            irq_out <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        SERVICE: begin
          if (eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prio_irq_ctrl.md
Name: prio_irq_ctrl

Overview:
- Interrupt controller that captures edge-triggered requests, masks them, and picks one with a fixed-priority encoder (bit 0 = highest priority).
- Presents one interrupt at a time to a single consumer through an irq/ack/eoi handshake.
- Sits between peripheral interrupt lines and the CPU/sequencer; owns and sequences the priority-encode function.

Parameters:
- N_IRQ, 8, number of interrupt inputs (2..32).
- ID_W, $clog2(N_IRQ), width of the interrupt ID.
- ACK_TIMEOUT, 16, cycles allowed in REQ before abandon; used only with IRQ_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  N_IRQ  raw interrupt lines; a 0->1 transition between samples raises a request.
- mask  input  N_IRQ  1 = line blocked from selection (capture still occurs).
- irq_out  output  1  interrupt presented to consumer.
- irq_id  output  ID_W  index of presented/in-service interrupt.
- in_service  output  1  consumer has acked and not yet issued eoi.
- pending  output  N_IRQ  captured, not-yet-acked requests.
- ack  input  1  consumer accepts presented interrupt.
- eoi  input  1  consumer finished servicing.
- timeout  output  1  one-cycle pulse on ack timeout (IRQ_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, immediate): state=IDLE, irq_out=0, irq_id=0, in_service=0, pending=0, irq_prev=0, timeout=0. Reset mid-handshake discards everything, including pending.
- Edge capture: irq_prev <= irq_in each cycle. pending_next = (pending & ~clr) | (irq_in & ~irq_prev). Set wins over clear on the same bit in the same cycle.
- Selection: eligible = pending & ~mask. Winner = lowest set index of eligible. If no bit is eligible, no selection.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If eligible != 0: irq_id <= winner, irq_out <= 1, go REQ.
  - ack and eoi are ignored.
- REQ:
  - irq_out=1; irq_id is held stable. No preemption: a newly pending higher-priority line does not change irq_id.
  - Masking the selected line while in REQ does not retract it.
  - On ack: clr[irq_id]=1, irq_out <= 0, in_service <= 1, go SERVICE.
  - eoi is ignored.
- SERVICE:
  - irq_id is held. On eoi: in_service <= 0, go IDLE.
  - ack is ignored.
  - A new selection can occur on the cycle after return to IDLE.
- Latency: irq_in first sampled high at edge k sets pending at edge k; with state IDLE and the line unmasked, irq_out is high after edge k+1.
- ack and eoi asserted in the same cycle in REQ: ack is taken and eoi is ignored. Service is not complete until a later eoi.
- A line held high raises only one request; it must fall and rise again to re-request.
- Masked pending bits persist. Unmasking later makes them eligible.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(ACK_TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches ACK_TIMEOUT with no ack: irq_out <= 0, timeout pulses for 1 cycle, go IDLE.
  - The pending bit is NOT cleared, so the same line may be re-presented.
  - ack in the same cycle as expiry wins; no timeout occurs.
- Undefined: no counter exists, timeout is tied 0, and REQ waits for ack indefinitely.

Test Plan:
- Reset then irq_in=8'b0010_0100 in one cycle, mask=0 -> pending=8'h24; irq_out=1 with irq_id=2 two edges later; ack -> pending=8'h20, in_service=1; eoi -> irq_id=5 presented next.
- irq_in 0->1 on bit 6 and stays high; ack; eoi -> no second request. Drop bit 6, raise it again -> re-presented with irq_id=6.
- mask=8'h01, irq_in bits 0 and 3 rise -> irq_id=3 served first. Then mask=0 -> irq_id=0 presented, with pending bit 0 retained throughout.
- In REQ with irq_id=4, raise bit 1 -> irq_id stays 4 until ack. Bit 1 is presented only after eoi.
- Assert rst asynchronously (mid-cycle) while in SERVICE with pending=8'h81 -> all outputs and pending are 0 immediately. After release, no irq_out without new edges.
- IRQ_TIMEOUT_EN, ACK_TIMEOUT=4, no ack -> irq_out drops after 4 REQ cycles, timeout=1 for one cycle, pending bit kept, and the same irq_id is re-presented next cycle.
